// File: rtl/boot_uart_host.sv
// ============================================================================
// Module   : boot_uart_host
// Purpose  : Initiator end of the UART bootloader link. Streams a program
//            image from a word-addressed source memory into a target IMEM
//            (load) or reads a target DMEM back word by word (dump).
//            Contains its own 8N1 transmitter, receiver and frame builder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_uart_host #(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  dump_valid,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  tx,
    input  logic                  rx
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int BW       = $clog2(BAUD_DIV + 1);
    localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] DIV_M1   = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_CNT = BW'(BAUD_DIV / 2);
    localparam logic [TW-1:0] TO_M1    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEND  = 3'd2,
        S_RECV  = 3'd3,
        S_NEXT  = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH:0]   wc_q, wc_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic                  fetch_wait_q, fetch_wait_d;
    logic [31:0]           data_q, data_d;
    logic [2:0]            send_idx_q, send_idx_d;
    logic [1:0]            rxcnt_q, rxcnt_d;
    logic [TW-1:0]         to_q, to_d;
    logic [9:0]            tx_sh_q, tx_sh_d;
    logic                  tx_act_q, tx_act_d;
    logic [3:0]            tx_bit_q, tx_bit_d;
    logic [BW-1:0]         tx_cnt_q, tx_cnt_d;
    logic [ADDR_WIDTH-1:0] src_addr_q, src_addr_d;
    logic                  dump_valid_q, dump_valid_d;
    logic [ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
    logic [31:0]           dump_data_q, dump_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    // Receiver registers
    logic                  rx_s1_q, rx_s2_q, rx_prev_q;
    logic                  rx_act_q;
    logic [3:0]            rx_bit_q;
    logic [BW-1:0]         rx_cnt_q;
    logic [7:0]            rx_sh_q;
    logic                  rx_vld_q;

    logic                  w_tx_end, w_tx_ready, w_tx_load;
    logic [2:0]            w_last_send;
    logic [ADDR_WIDTH:0]   w_idx_inc;
    logic [15:0]           w_addr16;
    logic [7:0]            w_frame_byte;

    assign tx         = tx_sh_q[0];
    assign src_addr   = src_addr_q;
    assign dump_valid = dump_valid_q;
    assign dump_addr  = dump_addr_q;
    assign dump_data  = dump_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

    // Receiver: 2-FF synchroniser, start-bit recheck, mid-bit sampling, stop-bit filter
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_act_q  <= 1'b0;
            rx_bit_q  <= 4'd0;
            rx_cnt_q  <= '0;
            rx_sh_q   <= 8'h00;
            rx_vld_q  <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_vld_q  <= 1'b0;
            if (!rx_act_q) begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_act_q <= 1'b1;
                    rx_bit_q <= 4'd0;
                    rx_cnt_q <= '0;
                end
            end else if (rx_bit_q == 4'd0) begin
                if (rx_cnt_q == HALF_CNT) begin
                    if (rx_s2_q) begin
                        rx_act_q <= 1'b0;   // line went back high: glitch
                    end else begin
                        rx_bit_q <= 4'd1;
                        rx_cnt_q <= '0;
                    end
                end else begin
                    rx_cnt_q <= rx_cnt_q + 1'b1;
                end
            end else if (rx_cnt_q == DIV_M1) begin
                rx_cnt_q <= '0;
                if (rx_bit_q == 4'd9) begin
                    rx_act_q <= 1'b0;
                    rx_vld_q <= rx_s2_q;    // a low stop bit drops the byte
                end else begin
                    rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_q <= rx_bit_q + 4'd1;
                end
            end else begin
                rx_cnt_q <= rx_cnt_q + 1'b1;
            end
        end
    end

    // State and datapath register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            wc_q         <= '0;
            idx_q        <= '0;
            fetch_wait_q <= 1'b0;
            data_q       <= 32'h0;
            send_idx_q   <= 3'd0;
            rxcnt_q      <= 2'd0;
            to_q         <= '0;
            tx_sh_q      <= 10'h3FF;
            tx_act_q     <= 1'b0;
            tx_bit_q     <= 4'd0;
            tx_cnt_q     <= '0;
            src_addr_q   <= '0;
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= 32'h0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            wc_q         <= wc_d;
            idx_q        <= idx_d;
            fetch_wait_q <= fetch_wait_d;
            data_q       <= data_d;
            send_idx_q   <= send_idx_d;
            rxcnt_q      <= rxcnt_d;
            to_q         <= to_d;
            tx_sh_q      <= tx_sh_d;
            tx_act_q     <= tx_act_d;
            tx_bit_q     <= tx_bit_d;
            tx_cnt_q     <= tx_cnt_d;
            src_addr_q   <= src_addr_d;
            dump_valid_q <= dump_valid_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next-state logic: transfer sequencing, frame byte selection, transmitter
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        wc_d         = wc_q;
        idx_d        = idx_q;
        fetch_wait_d = fetch_wait_q;
        data_d       = data_q;
        send_idx_d   = send_idx_q;
        rxcnt_d      = rxcnt_q;
        to_d         = to_q;
        dump_valid_d = 1'b0;
        dump_addr_d  = dump_addr_q;
        dump_data_d  = dump_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        w_tx_load    = 1'b0;

        // Transmitter is free now, or frees at this edge (stop bit just ending)
        w_tx_end    = tx_act_q && (tx_bit_q == 4'd9) && (tx_cnt_q == DIV_M1);
        w_tx_ready  = !tx_act_q || w_tx_end;
        w_last_send = mode_q ? 3'd2 : 3'd6;
        w_idx_inc   = idx_q + 1'b1;
        w_addr16    = 16'(idx_q[ADDR_WIDTH-1:0]);

        case (send_idx_q)
            3'd0:    w_frame_byte = mode_q ? 8'h44 : 8'h4C;
            3'd1:    w_frame_byte = w_addr16[15:8];
            3'd2:    w_frame_byte = w_addr16[7:0];
            3'd3:    w_frame_byte = data_q[7:0];
            3'd4:    w_frame_byte = data_q[15:8];
            3'd5:    w_frame_byte = data_q[23:16];
            3'd6:    w_frame_byte = data_q[31:24];
            default: w_frame_byte = 8'h00;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d       = mode;
                    wc_d         = word_count;
                    idx_d        = '0;
                    error_d      = 1'b0;
                    busy_d       = 1'b1;
                    send_idx_d   = 3'd0;
                    fetch_wait_d = 1'b0;
                    if (word_count == '0) begin
                        state_d = S_FIN;
                    end else if (mode) begin
                        state_d = S_SEND;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                // src_addr already holds idx; memory answers one cycle later
                if (!fetch_wait_q) begin
                    fetch_wait_d = 1'b1;
                end else begin
                    data_d       = src_data;
                    fetch_wait_d = 1'b0;
                    state_d      = S_SEND;
                end
            end
            S_SEND: begin
                if (send_idx_q <= w_last_send) begin
                    if (w_tx_ready) begin
                        w_tx_load  = 1'b1;
                        send_idx_d = send_idx_q + 3'd1;
                        // Load frames move on while the last byte is on the
                        // wire so the next frame can follow without a gap.
                        if (!mode_q && (send_idx_q == w_last_send)) begin
                            send_idx_d = 3'd0;
                            state_d    = S_NEXT;
                        end
                    end
                end else if (!tx_act_q) begin
                    // Dump request fully sent: response window opens now
                    send_idx_d = 3'd0;
                    rxcnt_d    = 2'd0;
                    to_d       = '0;
                    state_d    = S_RECV;
                end
            end
            S_RECV: begin
                if (rx_vld_q) begin
                    dump_data_d = {rx_sh_q, dump_data_q[31:8]};
                    to_d        = '0;
                    rxcnt_d     = rxcnt_q + 2'd1;
                    if (rxcnt_q == 2'd3) begin
                        dump_valid_d = 1'b1;
                        dump_addr_d  = idx_q[ADDR_WIDTH-1:0];
                        state_d      = S_NEXT;
                    end
                end else if (to_q == TO_M1) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (w_idx_inc == wc_q) begin
                    // Hold busy until the final byte has left the line
                    if (!tx_act_q) begin
                        idx_d   = w_idx_inc;
                        state_d = S_FIN;
                    end
                end else begin
                    idx_d   = w_idx_inc;
                    state_d = mode_q ? S_SEND : S_FETCH;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        src_addr_d = idx_d[ADDR_WIDTH-1:0];

        tx_sh_d  = tx_sh_q;
        tx_act_d = tx_act_q;
        tx_bit_d = tx_bit_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_act_q) begin
            if (tx_cnt_q == DIV_M1) begin
                tx_cnt_d = '0;
                tx_bit_d = tx_bit_q + 4'd1;
                tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                if (tx_bit_q == 4'd9) begin
                    tx_act_d = 1'b0;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
        if (w_tx_load) begin
            tx_sh_d  = {1'b1, w_frame_byte, 1'b0};
            tx_act_d = 1'b1;
            tx_bit_d = 4'd0;
            tx_cnt_d = '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_boot_uart_host.sv
// ============================================================================
// Module   : tb_boot_uart_host
// Purpose  : Directed, table-driven bench for boot_uart_host (BAUD_DIV=10,
//            TIMEOUT_CYCLES=500): load/dump frames, responses, timeout,
//            zero-length transfer, rx glitch/framing error, mid-byte reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boot_uart_host;

    localparam int AW   = 10;
    localparam int BAUD = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [AW:0]   word_count;
    logic [AW-1:0] src_addr;
    logic [31:0]   src_data;
    logic          dump_valid;
    logic [AW-1:0] dump_addr;
    logic [31:0]   dump_data;
    logic          busy, done, error, tx;
    logic          rx = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] src;
        logic [7:0]  frame [7];
    } load_vec_t;

    typedef struct {
        logic [7:0]    resp [4];
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } dump_vec_t;

    load_vec_t lv [4];
    dump_vec_t dv [2];

    logic [31:0]   mem [0:15];
    logic [7:0]    byte_q [$];
    int            start_q [$];
    logic          stop_q [$];
    logic [AW-1:0] dva_q [$];
    logic [31:0]   dvd_q [$];
    int            sa_q [$];
    int            sa_last = -1;
    int            done_cnt = 0;
    logic          tx_prev = 1'b1;

    boot_uart_host #(
        .CLK_FREQ       (1_000_000),
        .BAUD_RATE      (100_000),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (500)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .word_count (word_count),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .tx         (tx),
        .rx         (rx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        src_data <= mem[src_addr[3:0]];
    end

    // Event recorders, sampled on the falling edge
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (dump_valid === 1'b1) begin
            dva_q.push_back(dump_addr);
            dvd_q.push_back(dump_data);
        end
        if (busy === 1'b1 && int'(src_addr) != sa_last) begin
            sa_last = int'(src_addr);
            sa_q.push_back(sa_last);
        end
    end

    // UART decoder on tx
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_prev === 1'b1 && tx === 1'b0) begin
                start_q.push_back(cyc);
                repeat (BAUD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BAUD) @(negedge clk);
                stop_q.push_back(tx);
                byte_q.push_back(b);
            end
            tx_prev = tx;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        byte_q.delete(); start_q.delete(); stop_q.delete();
        dva_q.delete(); dvd_q.delete(); sa_q.delete();
        sa_last  = -1;
        done_cnt = 0;
    endtask

    task automatic do_start(input logic m, input int wc);
        @(negedge clk);
        start      = 1'b1;
        mode       = m;
        word_count = (AW + 1)'(wc);
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int busy_low, output int at_cyc);
        int n = 0;
        busy_low = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
            if (done !== 1'b1 && busy !== 1'b1) busy_low++;
        end
        at_cyc = cyc;
        chk("done_seen", done, 1);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int k = 0;
        while (byte_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("tx_bytes_reached", byte_q.size() >= n, 1);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb);
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = stopb;
        repeat (BAUD) @(negedge clk);
        rx = 1'b1;
        if (!stopb) repeat (2 * BAUD) @(negedge clk);
    endtask

    task automatic check_frames(input int first_vec, input int nvec, input string tag);
        chk({tag, "_nbytes"}, byte_q.size(), 7 * nvec);
        for (int v = 0; v < nvec; v++)
            for (int j = 0; j < 7; j++)
                if (7 * v + j < byte_q.size())
                    chk({tag, "_byte"}, byte_q[7 * v + j], lv[first_vec + v].frame[j]);
        for (int i = 1; i < start_q.size(); i++)
            chk({tag, "_gap"}, start_q[i] - start_q[i - 1], 10 * BAUD);
        for (int i = 0; i < stop_q.size(); i++)
            chk({tag, "_stop"}, stop_q[i], 1);
    endtask

    initial begin
        int bl, dc, t_end;

        // Load vectors: source word -> expected 7-byte frame
        lv[0].src = 32'hDEADBEEF; lv[0].frame = '{8'h4C, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        lv[1].src = 32'h11111111; lv[1].frame = '{8'h4C, 8'h00, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11};
        lv[2].src = 32'h22222222; lv[2].frame = '{8'h4C, 8'h00, 8'h01, 8'h22, 8'h22, 8'h22, 8'h22};
        lv[3].src = 32'h33333333; lv[3].frame = '{8'h4C, 8'h00, 8'h02, 8'h33, 8'h33, 8'h33, 8'h33};
        // Dump vectors: responder bytes -> expected (addr, word)
        dv[0].resp = '{8'h78, 8'h56, 8'h34, 8'h12}; dv[0].addr = 10'd0; dv[0].data = 32'h12345678;
        dv[1].resp = '{8'h04, 8'h03, 8'h02, 8'h01}; dv[1].addr = 10'd1; dv[1].data = 32'h01020304;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst = 1'b1; start = 1'b0; mode = 1'b0; word_count = '0;
        repeat (4) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dump_valid", dump_valid, 0);
        chk("rst_error", error, 0);
        chk("rst_src_addr", src_addr, 0);
        chk("rst_dump_addr", dump_addr, 0);
        chk("rst_dump_data", dump_data, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Load one word
        clear_logs();
        mem[0] = lv[0].src;
        do_start(1'b0, 1);
        wait_done(3000, bl, dc);
        repeat (20) @(negedge clk);
        check_frames(0, 1, "load1");
        chk("load1_done_cnt", done_cnt, 1);
        chk("load1_busy_low", bl, 0);

        // Load three words back to back
        clear_logs();
        for (int i = 0; i < 3; i++) mem[i] = lv[i + 1].src;
        do_start(1'b0, 3);
        wait_done(5000, bl, dc);
        repeat (20) @(negedge clk);
        check_frames(1, 3, "load3");
        chk("load3_done_cnt", done_cnt, 1);
        chk("load3_busy_low", bl, 0);
        chk("load3_sa_n", sa_q.size() >= 3, 1);
        for (int i = 0; i < 3; i++)
            if (i < sa_q.size()) chk("load3_src_addr", sa_q[i], i);

        // Dump two words with a responder
        clear_logs();
        do_start(1'b1, 2);
        for (int k = 0; k < 2; k++) begin
            wait_bytes(3 * (k + 1), 2000);
            repeat (BAUD) @(negedge clk);
            for (int j = 0; j < 4; j++) send_rx(dv[k].resp[j], 1'b1);
        end
        wait_done(2000, bl, dc);
        repeat (20) @(negedge clk);
        chk("dump_nbytes", byte_q.size(), 6);
        if (byte_q.size() == 6) begin
            chk("dump_cmd0", byte_q[0], 8'h44);
            chk("dump_lo0", byte_q[2], 8'h00);
            chk("dump_cmd1", byte_q[3], 8'h44);
            chk("dump_lo1", byte_q[5], 8'h01);
        end
        chk("dump_nvalid", dva_q.size(), 2);
        for (int k = 0; k < 2; k++)
            if (k < dva_q.size()) begin
                chk("dump_addr", dva_q[k], dv[k].addr);
                chk("dump_data", dvd_q[k], dv[k].data);
            end
        chk("dump_done_cnt", done_cnt, 1);
        chk("dump_error", error, 0);

        // Dump with a glitch and a framing-error byte ahead of the real reply
        clear_logs();
        do_start(1'b1, 1);
        wait_bytes(3, 2000);
        repeat (BAUD) @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        send_rx(8'hAA, 1'b0);
        for (int j = 0; j < 4; j++) send_rx(8'(j + 1), 1'b1);
        wait_done(2000, bl, dc);
        repeat (5) @(negedge clk);
        chk("rxflt_nvalid", dva_q.size(), 1);
        if (dva_q.size() > 0) chk("rxflt_data", dvd_q[0], 32'h04030201);
        chk("rxflt_error", error, 0);

        // Silent responder: timeout
        clear_logs();
        do_start(1'b1, 1);
        wait_bytes(3, 2000);
        t_end = (start_q.size() >= 3) ? start_q[2] + 10 * BAUD : 0;
        wait_done(2000, bl, dc);
        chk("to_error", error, 1);
        chk("to_latency_ok", (dc - t_end >= 495) && (dc - t_end <= 510), 1);
        chk("to_nvalid", dva_q.size(), 0);
        repeat (5) @(negedge clk);
        chk("to_error_sticky", error, 1);

        // Zero-length transfer; also clears the sticky error
        clear_logs();
        do_start(1'b0, 0);
        chk("wc0_error_cleared", error, 0);
        chk("wc0_busy1", busy, 1);
        chk("wc0_done_early", done, 0);
        chk("wc0_tx1", tx, 1);
        @(negedge clk);
        chk("wc0_done", done, 1);
        chk("wc0_busy_off", busy, 0);
        chk("wc0_tx2", tx, 1);
        @(negedge clk);
        chk("wc0_done_once", done, 0);
        chk("wc0_no_tx", byte_q.size(), 0);

        // Reset in the middle of a byte, then an immediate start
        mem[0] = 32'h00000000;
        do_start(1'b0, 1);
        repeat (150) @(negedge clk);
        chk("mid_tx_low", tx, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        rst        = 1'b0;
        start      = 1'b1;
        mode       = 1'b0;
        word_count = '0;
        @(negedge clk);
        start = 1'b0;
        chk("post_rst_accept", busy, 1);
        @(negedge clk);
        chk("post_rst_done", done, 1);

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/boot_uart_host.md
Name: boot_uart_host

Overview:
Initiator end of the UART bootloader link. It streams a program image from a word-addressed source memory into a target's IMEM ("load" mode), or reads back a target's DMEM word by word ("dump" mode). UART transmitter, receiver and framing are all inside the block. Used for self-boot from an on-chip image ROM and as the host model in SoC system benches.

Parameters:
CLK_FREQ, 100_000_000, clock frequency in Hz
BAUD_RATE, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD_RATE cycles per bit (integer division)
ADDR_WIDTH, 10, word-address width; legal range 1..16
DATA_WIDTH, 32, word width; fixed at 32
TIMEOUT_CYCLES, 1_000_000, maximum idle cycles allowed between dump response bytes

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle request to begin a transfer
mode  in  1  0 = load IMEM, 1 = dump DMEM; sampled when start is accepted
word_count  in  ADDR_WIDTH+1  number of words to transfer; sampled when start is accepted
src_addr  out  ADDR_WIDTH  source-memory word address (load mode)
src_data  in  32  source-memory read data; valid 1 cycle after src_addr
dump_valid  out  1  1-cycle pulse; a dump word is valid on dump_addr/dump_data
dump_addr  out  ADDR_WIDTH  word address of the dumped word
dump_data  out  32  dumped word
busy  out  1  high from the cycle after start is accepted until done
done  out  1  1-cycle pulse when the transfer ends (normally or on timeout)
error  out  1  sticky flag: a timeout occurred; cleared by the next accepted start or by rst
tx  out  1  UART transmit line, idle high
rx  in  1  UART receive line, asynchronous input

Behaviour:
- Reset values: tx=1, busy=0, done=0, dump_valid=0, error=0, src_addr=0, dump_addr=0, dump_data=0. FSM goes to IDLE. Reset mid-frame aborts the transfer immediately; tx returns high in the next cycle.
- UART format: 8N1, LSB first. Each bit lasts BAUD_DIV cycles, so one byte takes 10*BAUD_DIV cycles.
- rx passes through a 2-FF synchroniser. A falling edge starts reception. The start bit is rechecked at BAUD_DIV/2; if rx is high there, the event is a glitch and the receiver returns to idle. Each data bit is sampled at its mid-bit point. A stop bit of 0 discards the byte; it is not counted and does not reset the timeout.
- Frames: addresses are zero-extended to 16 bits and sent big-endian; data bytes are sent LSB first.
  - Load frame: 0x4C, addr_hi, addr_lo, d[7:0], d[15:8], d[23:16], d[31:24]. No response is expected.
  - Dump frame: 0x44, addr_hi, addr_lo. The responder returns 4 bytes, LSB first.
- Transmitter: a new byte starts in the cycle after the previous stop bit ends, so there is no idle gap inside a frame or between frames.
- FSM states:
  - IDLE: start=1 latches mode and word_count, sets idx=0, clears error, sets busy=1.
    - word_count=0: go to FIN.
    - Otherwise: load mode goes to FETCH; dump mode goes to SEND.
    - start while not in IDLE is ignored.
  - FETCH: drive src_addr=idx, wait 1 cycle, latch src_data, go to SEND.
  - SEND: shift out the frame bytes.
    - Load mode, after the last byte: go to NEXT.
    - Dump mode, after the last byte: go to RECV.
  - RECV: assemble 4 bytes into dump_data. Each received byte reloads the timeout counter.
    - After the 4th byte: dump_valid=1 for 1 cycle with dump_addr=idx, then go to NEXT.
    - Counter reaches TIMEOUT_CYCLES: error=1, go to FIN.
  - NEXT: idx+1. If the new idx equals word_count, go to FIN; otherwise go to FETCH (load) or SEND (dump).
  - FIN: done=1 for 1 cycle, busy=0, go to IDLE.
- Address wrap: word_count = 2^ADDR_WIDTH is legal; idx is ADDR_WIDTH+1 bits wide, so it never wraps mid-transfer.
- Bytes received outside RECV are dropped.

Test Plan:
- CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BAUD_DIV=10); load, word_count=1, src[0]=0xDEADBEEF -> tx carries 4C 00 00 EF BE AD DE; each byte is 100 cycles; done pulses once; busy is high throughout.
- Load, word_count=3, src = 0x11111111, 0x22222222, 0x33333333 -> 21 bytes with addr_lo = 00, 01, 02; no idle gaps on tx; src_addr steps 0, 1, 2.
- Dump, word_count=2; bench responder answers 78 56 34 12 then 04 03 02 01 -> dump_valid pulses twice: (0, 0x12345678) then (1, 0x01020304); done pulses once; error=0.
- Dump with a silent responder, TIMEOUT_CYCLES=500 -> error=1 and done pulses about 500 cycles after the third dump byte ends; a following start clears error.
- word_count=0 -> done pulses 2 cycles after start; tx stays high throughout.
- rx: a 3-cycle low glitch is ignored. A byte with stop bit 0 is not counted. rst asserted mid-byte gives tx=1 and busy=0 the next cycle; a start 0 cycles later is accepted.
